// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
//
// Purpose:
//   Push-button time-setting front end for a six-digit BCD time-of-day
//   counter. Three raw buttons are synchronized and debounced into one-cycle
//   press pulses. A mode press captures the running time into edit
//   registers. Further mode presses step through the hour, minute and second
//   fields. Up/down presses edit the selected field. The final mode press
//   writes the edited time back with a one-cycle load strobe. A per-digit
//   blank mask lets the display multiplexer blink the field being edited.
//
// Ports:
//   clk            system clock, all state updates on its rising edge
//   rst            synchronous active-high reset
//   btn_mode       raw asynchronous mode button, active-high
//   btn_up         raw asynchronous increment button, active-high
//   btn_down       raw asynchronous decrement button, active-high
//   cur_*          running time from the counter (BCD digits)
//   ld_*           edited time (BCD digits); the counter only takes it
//                  when load is high
//   load           one-cycle strobe that commits ld_* to the counter
//   set_active     high while a field is being edited
//   digit_blank    per-digit blank request, bit5=hr_tens ... bit0=sec_ones
// ---------------------------------------------------------------------------
module time_set_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [1:0] cur_hr_tens,
  input  logic [3:0] cur_hr_ones,
  input  logic [2:0] cur_min_tens,
  input  logic [3:0] cur_min_ones,
  input  logic [2:0] cur_sec_tens,
  input  logic [3:0] cur_sec_ones,
  output logic [1:0] ld_hr_tens,
  output logic [3:0] ld_hr_ones,
  output logic [2:0] ld_min_tens,
  output logic [3:0] ld_min_ones,
  output logic [2:0] ld_sec_tens,
  output logic [3:0] ld_sec_ones,
  output logic       load,
  output logic       set_active,
  output logic [5:0] digit_blank
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    RUN,
    SET_HR,
    SET_MIN,
    SET_SEC,
    COMMIT
  } state_t;

  // Button bit order used throughout: 0 = mode, 1 = up, 2 = down.
  logic [2:0]       btnRaw;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       level_q;
  logic [2:0]       levelPrev_q;
  logic [2:0]       press_q;
  logic [DEB_W-1:0] debCnt_q [3];

  logic       modeEv;
  logic       upEv;
  logic       downEv;
  logic       stepEv;
  logic       edited;

  state_t     state_q, state_d;
  logic [1:0] hrTens_q, hrTens_d;
  logic [3:0] hrOnes_q, hrOnes_d;
  logic [2:0] minTens_q, minTens_d;
  logic [3:0] minOnes_q, minOnes_d;
  logic [2:0] secTens_q, secTens_d;
  logic [3:0] secOnes_q, secOnes_d;

  logic [BLK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic             blinkPhase_q, blinkPhase_d;

  logic       load_q, load_d;
  logic       setActive_q, setActive_d;
  logic [5:0] digitBlank_q, digitBlank_d;

  assign btnRaw = {btn_down, btn_up, btn_mode};

  // Hours step, treating the BCD pair as one value in 00..23. A pair that
  // is not a legal hour (e.g. captured from a corrupted counter) snaps to 00
  // on the first edit so the user always starts from a sane value.
  function automatic logic [5:0] hrStep(input logic [1:0] tens,
                                        input logic [3:0] ones,
                                        input logic       up);
    logic [5:0] r;
    logic       valid;
    valid = ((tens < 2'd2) && (ones <= 4'd9)) ||
            ((tens == 2'd2) && (ones <= 4'd3));
    if (!valid) begin
      r = 6'h00;
    end else if (up) begin
      if ((tens == 2'd2) && (ones == 4'd3)) r = 6'h00;
      else if (ones == 4'd9)                r = {tens + 2'd1, 4'd0};
      else                                  r = {tens, ones + 4'd1};
    end else begin
      if ((tens == 2'd0) && (ones == 4'd0)) r = 6'h23;
      else if (ones == 4'd0)                r = {tens - 2'd1, 4'd9};
      else                                  r = {tens, ones - 4'd1};
    end
    return r;
  endfunction

  // Minutes/seconds step over 00..59 with the same snap-to-00 rule for
  // illegal captured pairs.
  function automatic logic [6:0] msStep(input logic [2:0] tens,
                                        input logic [3:0] ones,
                                        input logic       up);
    logic [6:0] r;
    logic       valid;
    valid = (tens <= 3'd5) && (ones <= 4'd9);
    if (!valid) begin
      r = 7'h00;
    end else if (up) begin
      if ((tens == 3'd5) && (ones == 4'd9)) r = 7'h00;
      else if (ones == 4'd9)                r = {tens + 3'd1, 4'd0};
      else                                  r = {tens, ones + 4'd1};
    end else begin
      if ((tens == 3'd0) && (ones == 4'd0)) r = 7'h59;
      else if (ones == 4'd0)                r = {tens - 3'd1, 4'd9};
      else                                  r = {tens, ones - 4'd1};
    end
    return r;
  endfunction

  // Input path: 2-FF synchronizer, then a stability counter per button.
  // The debounced level only flips after DEB_CYCLES consecutive synchronized
  // samples disagree with it; any agreeing sample restarts the count. The
  // press pulse is taken from a delayed copy of the level, which fixes the
  // raw-edge-to-pulse latency at DEB_CYCLES+3 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      levelPrev_q <= '0;
      press_q     <= '0;
      for (int i = 0; i < 3; i++) begin
        debCnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= btnRaw;
      sync2_q     <= sync1_q;
      levelPrev_q <= level_q;
      press_q     <= level_q & ~levelPrev_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          debCnt_q[i] <= '0;
        end else if (debCnt_q[i] == DEB_LAST) begin
          level_q[i]  <= sync2_q[i];
          debCnt_q[i] <= '0;
        end else begin
          debCnt_q[i] <= debCnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  // Event decode: mode always wins; simultaneous up and down cancel.
  assign modeEv = press_q[0];
  assign upEv   = press_q[1] & ~press_q[2];
  assign downEv = press_q[2] & ~press_q[1];
  assign stepEv = upEv | downEv;

  // Next-state logic for the editing FSM, the edit registers, the blink
  // timer and the registered outputs. Outputs are derived from the next
  // state so they change on the same edge as the state itself.
  always_comb begin
    state_d      = state_q;
    hrTens_d     = hrTens_q;
    hrOnes_d     = hrOnes_q;
    minTens_d    = minTens_q;
    minOnes_d    = minOnes_q;
    secTens_d    = secTens_q;
    secOnes_d    = secOnes_q;
    edited       = 1'b0;
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    load_d       = 1'b0;
    setActive_d  = 1'b0;
    digitBlank_d = 6'b000000;

    case (state_q)
      RUN: begin
        if (modeEv) begin
          state_d   = SET_HR;
          hrTens_d  = cur_hr_tens;
          hrOnes_d  = cur_hr_ones;
          minTens_d = cur_min_tens;
          minOnes_d = cur_min_ones;
          secTens_d = cur_sec_tens;
          secOnes_d = cur_sec_ones;
        end
      end
      SET_HR: begin
        if (modeEv) begin
          state_d = SET_MIN;
        end else if (stepEv) begin
          {hrTens_d, hrOnes_d} = hrStep(hrTens_q, hrOnes_q, upEv);
          edited = 1'b1;
        end
      end
      SET_MIN: begin
        if (modeEv) begin
          state_d = SET_SEC;
        end else if (stepEv) begin
          {minTens_d, minOnes_d} = msStep(minTens_q, minOnes_q, upEv);
          edited = 1'b1;
        end
      end
      SET_SEC: begin
        if (modeEv) begin
          state_d = COMMIT;
        end else if (stepEv) begin
          {secTens_d, secOnes_d} = msStep(secTens_q, secOnes_q, upEv);
          edited = 1'b1;
        end
      end
      COMMIT: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Restart the blink on any state change or edit so the new value is
    // shown immediately rather than possibly landing in a blanked phase.
    if ((state_d != state_q) || edited) begin
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b0;
    end else if (blinkCnt_q == BLK_LAST) begin
      blinkCnt_d   = '0;
      blinkPhase_d = ~blinkPhase_q;
    end else begin
      blinkCnt_d   = blinkCnt_q + BLK_W'(1);
    end

    load_d = (state_d == COMMIT);

    case (state_d)
      SET_HR: begin
        setActive_d  = 1'b1;
        digitBlank_d = {blinkPhase_d, blinkPhase_d, 4'b0000};
      end
      SET_MIN: begin
        setActive_d  = 1'b1;
        digitBlank_d = {2'b00, blinkPhase_d, blinkPhase_d, 2'b00};
      end
      SET_SEC: begin
        setActive_d  = 1'b1;
        digitBlank_d = {4'b0000, blinkPhase_d, blinkPhase_d};
      end
      default: begin
        setActive_d  = 1'b0;
        digitBlank_d = 6'b000000;
      end
    endcase
  end

  // State, edit registers, blink timer and output registers. Reset throws
  // away any edit in progress without ever raising load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      hrTens_q     <= '0;
      hrOnes_q     <= '0;
      minTens_q    <= '0;
      minOnes_q    <= '0;
      secTens_q    <= '0;
      secOnes_q    <= '0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      load_q       <= 1'b0;
      setActive_q  <= 1'b0;
      digitBlank_q <= '0;
    end else begin
      state_q      <= state_d;
      hrTens_q     <= hrTens_d;
      hrOnes_q     <= hrOnes_d;
      minTens_q    <= minTens_d;
      minOnes_q    <= minOnes_d;
      secTens_q    <= secTens_d;
      secOnes_q    <= secOnes_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      load_q       <= load_d;
      setActive_q  <= setActive_d;
      digitBlank_q <= digitBlank_d;
    end
  end

  assign ld_hr_tens  = hrTens_q;
  assign ld_hr_ones  = hrOnes_q;
  assign ld_min_tens = minTens_q;
  assign ld_min_ones = minOnes_q;
  assign ld_sec_tens = secTens_q;
  assign ld_sec_ones = secOnes_q;
  assign load        = load_q;
  assign set_active  = setActive_q;
  assign digit_blank = digitBlank_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl
//
// Purpose:
//   Directed testbench for time_set_ctrl with short debounce and blink
//   periods. Each scenario task drives raw buttons and the running time and
//   compares outputs against hand-derived values.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_up, btn_down;
  logic [1:0] cur_hr_tens;
  logic [3:0] cur_hr_ones;
  logic [2:0] cur_min_tens;
  logic [3:0] cur_min_ones;
  logic [2:0] cur_sec_tens;
  logic [3:0] cur_sec_ones;
  logic [1:0] ld_hr_tens;
  logic [3:0] ld_hr_ones;
  logic [2:0] ld_min_tens;
  logic [3:0] ld_min_ones;
  logic [2:0] ld_sec_tens;
  logic [3:0] ld_sec_ones;
  logic       load, set_active;
  logic [5:0] digit_blank;

  logic [5:0] ldHr;
  logic [6:0] ldMin, ldSec;

  int checks = 0;
  int errors = 0;

  assign ldHr  = {ld_hr_tens, ld_hr_ones};
  assign ldMin = {ld_min_tens, ld_min_ones};
  assign ldSec = {ld_sec_tens, ld_sec_ones};

  time_set_ctrl #(.DEB_CYCLES(DEB), .BLINK_DIV(BLK)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .cur_hr_tens  (cur_hr_tens),
    .cur_hr_ones  (cur_hr_ones),
    .cur_min_tens (cur_min_tens),
    .cur_min_ones (cur_min_ones),
    .cur_sec_tens (cur_sec_tens),
    .cur_sec_ones (cur_sec_ones),
    .ld_hr_tens   (ld_hr_tens),
    .ld_hr_ones   (ld_hr_ones),
    .ld_min_tens  (ld_min_tens),
    .ld_min_ones  (ld_min_ones),
    .ld_sec_tens  (ld_sec_tens),
    .ld_sec_ones  (ld_sec_ones),
    .load         (load),
    .set_active   (set_active),
    .digit_blank  (digit_blank)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the three raw buttons.
  task automatic applyStimulus(input logic m, input logic u, input logic d);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
  endtask

  task automatic setCur(input logic [5:0] hr, input logic [6:0] mn,
                        input logic [6:0] sc);
    {cur_hr_tens, cur_hr_ones}   = hr;
    {cur_min_tens, cur_min_ones} = mn;
    {cur_sec_tens, cur_sec_ones} = sc;
  endtask

  // Hold buttons until the edge on which the FSM reacts: pulse appears
  // DEB+3 edges after the raw edge, the FSM acts one edge later.
  task automatic pressWait(input logic m, input logic u, input logic d);
    applyStimulus(m, u, d);
    waitEdges(DEB + 4);
  endtask

  task automatic releaseAll();
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitEdges(12);
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    pressWait(m, u, d);
    releaseAll();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    waitEdges(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (ldHr !== 6'h00 || ldMin !== 7'h00 || ldSec !== 7'h00) begin
      errors++; $display("[TB] FAIL reset_ld: got %h:%h:%h expected 00:00:00", ldHr, ldMin, ldSec); end
    checks++; if (load !== 1'b0 || set_active !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: load=%b set_active=%b expected 0 0", load, set_active); end
    checks++; if (digit_blank !== 6'b000000) begin
      errors++; $display("[TB] FAIL reset_blank: got %b expected 000000", digit_blank); end
  endtask

  task automatic test_debounce();
    doReset();
    setCur(6'h05, 7'h00, 7'h00);
    press(1'b1, 1'b0, 1'b0);
    checks++; if (set_active !== 1'b1 || ldHr !== 6'h05) begin
      errors++; $display("[TB] FAIL deb_enter: set_active=%b hr=%h expected 1 05", set_active, ldHr); end
    applyStimulus(1'b0, 1'b1, 1'b0); waitEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0); waitEdges(1);
    applyStimulus(1'b0, 1'b1, 1'b0); waitEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0); waitEdges(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= DEB + 3; k++) begin
      waitEdges(1);
      checks++; if (ldHr !== 6'h05) begin
        errors++; $display("[TB] FAIL deb_early: edge %0d hr=%h expected 05", k, ldHr); end
    end
    waitEdges(1);
    checks++; if (ldHr !== 6'h06) begin
      errors++; $display("[TB] FAIL deb_latency: hr=%h expected 06", ldHr); end
    waitEdges(5);
    releaseAll();
    waitEdges(10);
    checks++; if (ldHr !== 6'h06) begin
      errors++; $display("[TB] FAIL deb_release: hr=%h expected 06", ldHr); end
  endtask

  task automatic test_capture_commit();
    doReset();
    setCur(6'h12, 7'h34, 7'h56);
    pressWait(1'b1, 1'b0, 1'b0);
    checks++; if (set_active !== 1'b1 || load !== 1'b0) begin
      errors++; $display("[TB] FAIL cap_active: set_active=%b load=%b expected 1 0", set_active, load); end
    checks++; if (ldHr !== 6'h12 || ldMin !== 7'h34 || ldSec !== 7'h56) begin
      errors++; $display("[TB] FAIL cap_values: got %h:%h:%h expected 12:34:56", ldHr, ldMin, ldSec); end
    releaseAll();
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    setCur(6'h00, 7'h00, 7'h00);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitEdges(DEB + 3);
    checks++; if (load !== 1'b0 || set_active !== 1'b1) begin
      errors++; $display("[TB] FAIL commit_early: load=%b set_active=%b expected 0 1", load, set_active); end
    waitEdges(1);
    checks++; if (load !== 1'b1 || set_active !== 1'b0) begin
      errors++; $display("[TB] FAIL commit_load: load=%b set_active=%b expected 1 0", load, set_active); end
    checks++; if (ldHr !== 6'h12 || ldMin !== 7'h34 || ldSec !== 7'h56) begin
      errors++; $display("[TB] FAIL commit_values: got %h:%h:%h expected 12:34:56", ldHr, ldMin, ldSec); end
    waitEdges(1);
    checks++; if (load !== 1'b0 || set_active !== 1'b0 || digit_blank !== 6'b000000) begin
      errors++; $display("[TB] FAIL commit_run: load=%b set_active=%b blank=%b expected 0 0 000000", load, set_active, digit_blank); end
    releaseAll();
    press(1'b0, 1'b1, 1'b0);
    checks++; if (ldHr !== 6'h12 || set_active !== 1'b0 || load !== 1'b0) begin
      errors++; $display("[TB] FAIL run_ignore_up: hr=%h set_active=%b load=%b expected 12 0 0", ldHr, set_active, load); end
  endtask

  task automatic test_hour_wrap();
    doReset();
    setCur(6'h23, 7'h00, 7'h00);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    checks++; if (ldHr !== 6'h00) begin
      errors++; $display("[TB] FAIL hr_up_wrap: hr=%h expected 00", ldHr); end
    press(1'b0, 1'b0, 1'b1);
    checks++; if (ldHr !== 6'h23) begin
      errors++; $display("[TB] FAIL hr_down_wrap: hr=%h expected 23", ldHr); end
    press(1'b0, 1'b0, 1'b1);
    checks++; if (ldHr !== 6'h22) begin
      errors++; $display("[TB] FAIL hr_down: hr=%h expected 22", ldHr); end

    doReset();
    setCur(6'h09, 7'h45, 7'h12);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    checks++; if (ldHr !== 6'h10) begin
      errors++; $display("[TB] FAIL hr_carry: hr=%h expected 10", ldHr); end
    for (int i = 0; i < 9; i++) press(1'b0, 1'b1, 1'b0);
    checks++; if (ldHr !== 6'h19 || ldMin !== 7'h45 || ldSec !== 7'h12) begin
      errors++; $display("[TB] FAIL hr_up10: got %h:%h:%h expected 19:45:12", ldHr, ldMin, ldSec); end

    doReset();
    setCur(6'h35, 7'h7A, 7'h00);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    checks++; if (ldHr !== 6'h00 || ldMin !== 7'h7A) begin
      errors++; $display("[TB] FAIL hr_invalid: hr=%h min=%h expected 00 7a", ldHr, ldMin); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    checks++; if (ldMin !== 7'h00 || ldHr !== 6'h00) begin
      errors++; $display("[TB] FAIL min_invalid: min=%h hr=%h expected 00 00", ldMin, ldHr); end
  endtask

  task automatic test_min_sec_wrap();
    doReset();
    setCur(6'h08, 7'h59, 7'h00);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    checks++; if (ldMin !== 7'h00 || ldHr !== 6'h08) begin
      errors++; $display("[TB] FAIL min_up_wrap: min=%h hr=%h expected 00 08", ldMin, ldHr); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    checks++; if (ldSec !== 7'h59 || ldMin !== 7'h00) begin
      errors++; $display("[TB] FAIL sec_down_wrap: sec=%h min=%h expected 59 00", ldSec, ldMin); end
    press(1'b0, 1'b1, 1'b0);
    checks++; if (ldSec !== 7'h00) begin
      errors++; $display("[TB] FAIL sec_up_wrap: sec=%h expected 00", ldSec); end
  endtask

  task automatic test_conflicts();
    doReset();
    setCur(6'h10, 7'h20, 7'h30);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    checks++; if (ldMin !== 7'h20) begin
      errors++; $display("[TB] FAIL updown_cancel: min=%h expected 20", ldMin); end
    press(1'b1, 1'b1, 1'b0);
    checks++; if (ldHr !== 6'h10 || ldMin !== 7'h20 || ldSec !== 7'h30) begin
      errors++; $display("[TB] FAIL mode_priority: got %h:%h:%h expected 10:20:30", ldHr, ldMin, ldSec); end
    checks++; if (set_active !== 1'b1 || digit_blank !== 6'b000011) begin
      errors++; $display("[TB] FAIL mode_to_sec: set_active=%b blank=%b expected 1 000011", set_active, digit_blank); end
    rst = 1'b1;
    waitEdges(1);
    checks++; if (ldHr !== 6'h00 || ldMin !== 7'h00 || ldSec !== 7'h00) begin
      errors++; $display("[TB] FAIL rst_mid_ld: got %h:%h:%h expected 00:00:00", ldHr, ldMin, ldSec); end
    checks++; if (load !== 1'b0 || set_active !== 1'b0 || digit_blank !== 6'b000000) begin
      errors++; $display("[TB] FAIL rst_mid_flags: load=%b set_active=%b blank=%b expected 0 0 000000", load, set_active, digit_blank); end
    waitEdges(1);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      waitEdges(1);
      checks++; if (load !== 1'b0 || set_active !== 1'b0) begin
        errors++; $display("[TB] FAIL rst_no_load: cycle %0d load=%b set_active=%b expected 0 0", k, load, set_active); end
    end
  endtask

  task automatic test_blink();
    logic [5:0] exp;
    doReset();
    setCur(6'h00, 7'h00, 7'h00);
    pressWait(1'b1, 1'b0, 1'b0);
    checks++; if (digit_blank !== 6'b000000) begin
      errors++; $display("[TB] FAIL blink_enter: blank=%b expected 000000", digit_blank); end
    for (int k = 1; k <= 2 * BLK; k++) begin
      waitEdges(1);
      exp = (k >= BLK && k < 2 * BLK) ? 6'b110000 : 6'b000000;
      checks++; if (digit_blank !== exp) begin
        errors++; $display("[TB] FAIL blink_hr: cycle %0d blank=%b expected %b", k, digit_blank, exp); end
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitEdges(DEB + 4);
    checks++; if (digit_blank !== 6'b000000 || ldHr !== 6'h01) begin
      errors++; $display("[TB] FAIL blink_edit: blank=%b hr=%h expected 000000 01", digit_blank, ldHr); end
    for (int k = 1; k <= BLK; k++) begin
      waitEdges(1);
      exp = (k == BLK) ? 6'b110000 : 6'b000000;
      checks++; if (digit_blank !== exp) begin
        errors++; $display("[TB] FAIL blink_after_edit: cycle %0d blank=%b expected %b", k, digit_blank, exp); end
    end
    releaseAll();
    press(1'b1, 1'b0, 1'b0);
    checks++; if (digit_blank !== 6'b001100) begin
      errors++; $display("[TB] FAIL blink_min: blank=%b expected 001100", digit_blank); end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    checks++; if (digit_blank !== 6'b000000 || set_active !== 1'b0) begin
      errors++; $display("[TB] FAIL blink_run: blank=%b set_active=%b expected 000000 0", digit_blank, set_active); end
  endtask

  // Scenario sequence.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    setCur(6'h00, 7'h00, 7'h00);
    test_reset();
    test_debounce();
    test_capture_commit();
    test_hour_wrap();
    test_min_sec_wrap();
    test_conflicts();
    test_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
